// File: rtl/writeback_rr_pkg.sv
// Shared writeback widths, payload layouts and arbitration helpers.
// Warp/register/data widths live here so every writeback block agrees on them.
package writeback_rr_pkg;

    localparam int unsigned DEPTH_WARP   = 3;
    localparam int unsigned REGIDX_WIDTH = 5;
    localparam int unsigned REGEXT_WIDTH = 3;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned NUM_THREAD   = 4;
    localparam int unsigned REGW         = REGIDX_WIDTH + REGEXT_WIDTH;

    typedef struct packed {
        logic [DEPTH_WARP-1:0] warp_id;
        logic                  wxd;
        logic [REGW-1:0]       reg_idxw;
        logic [XLEN-1:0]       wb_wxd_rd;
    } x_entry_t;

    typedef struct packed {
        logic [DEPTH_WARP-1:0]      warp_id;
        logic                       wvd;
        logic [REGW-1:0]            reg_idxw;
        logic [NUM_THREAD-1:0]      wvd_mask;
        logic [XLEN*NUM_THREAD-1:0] wb_wvd_rd;
    } v_entry_t;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (v[i-1]) r = 4'(i - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/writeback_rr_if.sv
// Writeback bundle: per-source x/v inputs and the registered x/v results.
interface writeback_rr_if
    import writeback_rr_pkg::*;
#(
    parameter int unsigned NUM_X = 6,
    parameter int unsigned NUM_V = 6
);

    logic [NUM_X-1:0]                 in_x_valid_i;
    logic [NUM_X-1:0]                 in_x_ready_o;
    logic [DEPTH_WARP*NUM_X-1:0]      in_x_warp_id_i;
    logic [NUM_X-1:0]                 in_x_wxd_i;
    logic [REGW*NUM_X-1:0]            in_x_reg_idxw_i;
    logic [XLEN*NUM_X-1:0]            in_x_wb_wxd_rd_i;

    logic [NUM_V-1:0]                 in_v_valid_i;
    logic [NUM_V-1:0]                 in_v_ready_o;
    logic [DEPTH_WARP*NUM_V-1:0]      in_v_warp_id_i;
    logic [NUM_V-1:0]                 in_v_wvd_i;
    logic [REGW*NUM_V-1:0]            in_v_reg_idxw_i;
    logic [NUM_THREAD*NUM_V-1:0]      in_v_wvd_mask_i;
    logic [XLEN*NUM_THREAD*NUM_V-1:0] in_v_wb_wvd_rd_i;

    logic                             out_x_valid_o;
    logic                             out_x_ready_i;
    logic [DEPTH_WARP-1:0]            out_x_warp_id_o;
    logic                             out_x_wxd_o;
    logic [REGW-1:0]                  out_x_reg_idxw_o;
    logic [XLEN-1:0]                  out_x_wb_wxd_rd_o;

    logic                             out_v_valid_o;
    logic                             out_v_ready_i;
    logic [DEPTH_WARP-1:0]            out_v_warp_id_o;
    logic                             out_v_wvd_o;
    logic [REGW-1:0]                  out_v_reg_idxw_o;
    logic [NUM_THREAD-1:0]            out_v_wvd_mask_o;
    logic [XLEN*NUM_THREAD-1:0]       out_v_wb_wvd_rd_o;

    modport slave (
        input  in_x_valid_i, in_x_warp_id_i, in_x_wxd_i, in_x_reg_idxw_i, in_x_wb_wxd_rd_i,
        output in_x_ready_o,
        input  in_v_valid_i, in_v_warp_id_i, in_v_wvd_i, in_v_reg_idxw_i, in_v_wvd_mask_i,
        input  in_v_wb_wvd_rd_i,
        output in_v_ready_o,
        output out_x_valid_o, out_x_warp_id_o, out_x_wxd_o, out_x_reg_idxw_o, out_x_wb_wxd_rd_o,
        input  out_x_ready_i,
        output out_v_valid_o, out_v_warp_id_o, out_v_wvd_o, out_v_reg_idxw_o, out_v_wvd_mask_o,
        output out_v_wb_wvd_rd_o,
        input  out_v_ready_i
    );

    modport master (
        output in_x_valid_i, in_x_warp_id_i, in_x_wxd_i, in_x_reg_idxw_i, in_x_wb_wxd_rd_i,
        input  in_x_ready_o,
        output in_v_valid_i, in_v_warp_id_i, in_v_wvd_i, in_v_reg_idxw_i, in_v_wvd_mask_i,
        output in_v_wb_wvd_rd_i,
        input  in_v_ready_o,
        input  out_x_valid_o, out_x_warp_id_o, out_x_wxd_o, out_x_reg_idxw_o, out_x_wb_wxd_rd_o,
        output out_x_ready_i,
        input  out_v_valid_o, out_v_warp_id_o, out_v_wvd_o, out_v_reg_idxw_o, out_v_wvd_mask_o,
        input  out_v_wb_wvd_rd_o,
        output out_v_ready_i
    );

endinterface

// File: rtl/writeback_rr_wb_arb_chan.sv
// One writeback channel: N-way arbiter feeding a single registered output slot.
// WB_ROUND_ROBIN_EN selects round-robin grant; otherwise lowest index wins.
module wb_arb_chan
    import writeback_rr_pkg::*;
#(
    parameter int unsigned NUM_IN = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [DATA_W*NUM_IN-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data
);

    localparam int unsigned PTR_W = ptr_width(NUM_IN);

    logic              free;
    logic              any_valid;
    logic              accept;
    logic [15:0]       valid_ext;
    logic [3:0]        pick;
    logic [PTR_W-1:0]  gidx;

`ifdef WB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]  ptr;
    logic [15:0]       above;

    // Requests at or above ptr win first; otherwise wrap to the lowest request.
    always_comb begin
        valid_ext = 16'(in_valid);
        above     = valid_ext & ~((16'd1 << ptr) - 16'd1);
        pick      = (above != '0) ? lowest_set(above) : lowest_set(valid_ext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gidx == PTR_W'(NUM_IN - 1)) ? '0 : gidx + 1'b1;
        end
    end
`else
    always_comb begin
        valid_ext = 16'(in_valid);
        pick      = lowest_set(valid_ext);
    end
`endif

    assign gidx      = PTR_W'(pick);
    assign any_valid = |in_valid;
    assign free      = !out_valid || out_ready;
    assign accept    = any_valid && free;
    assign in_ready  = accept ? (NUM_IN'(1) << gidx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (free) begin
            out_valid <= any_valid;
        end
    end

    // Payload is meaningless while out_valid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_data <= in_data[gidx*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/writeback_rr.sv
// Writeback collector: independent x and v channels, each arbitrated into one output slot.
// Define WB_ROUND_ROBIN_EN for round-robin grant; default build uses fixed lowest-index priority.
module writeback_rr
    import writeback_rr_pkg::*;
#(
    parameter int unsigned NUM_X = 6,
    parameter int unsigned NUM_V = 6
) (
    input logic           clk,
    input logic           rst,
    writeback_rr_if.slave bus
);

    localparam int unsigned XW = $bits(x_entry_t);
    localparam int unsigned VW = $bits(v_entry_t);

    logic [XW*NUM_X-1:0] x_flat;
    logic [VW*NUM_V-1:0] v_flat;
    x_entry_t            x_out;
    v_entry_t            v_out;

    // Each source's fields are packed in the same order as the entry structs.
    always_comb begin
        x_flat = '0;
        for (int unsigned n = 0; n < NUM_X; n++) begin
            x_flat[n*XW +: XW] = {bus.in_x_warp_id_i[n*DEPTH_WARP +: DEPTH_WARP],
                                  bus.in_x_wxd_i[n],
                                  bus.in_x_reg_idxw_i[n*REGW +: REGW],
                                  bus.in_x_wb_wxd_rd_i[n*XLEN +: XLEN]};
        end
    end

    always_comb begin
        v_flat = '0;
        for (int unsigned m = 0; m < NUM_V; m++) begin
            v_flat[m*VW +: VW] = {bus.in_v_warp_id_i[m*DEPTH_WARP +: DEPTH_WARP],
                                  bus.in_v_wvd_i[m],
                                  bus.in_v_reg_idxw_i[m*REGW +: REGW],
                                  bus.in_v_wvd_mask_i[m*NUM_THREAD +: NUM_THREAD],
                                  bus.in_v_wb_wvd_rd_i[m*XLEN*NUM_THREAD +: XLEN*NUM_THREAD]};
        end
    end

    wb_arb_chan #(.NUM_IN(NUM_X), .DATA_W(XW)) x_chan (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_x_valid_i),
        .in_ready  (bus.in_x_ready_o),
        .in_data   (x_flat),
        .out_valid (bus.out_x_valid_o),
        .out_ready (bus.out_x_ready_i),
        .out_data  (x_out)
    );

    wb_arb_chan #(.NUM_IN(NUM_V), .DATA_W(VW)) v_chan (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_v_valid_i),
        .in_ready  (bus.in_v_ready_o),
        .in_data   (v_flat),
        .out_valid (bus.out_v_valid_o),
        .out_ready (bus.out_v_ready_i),
        .out_data  (v_out)
    );

    assign bus.out_x_warp_id_o   = x_out.warp_id;
    assign bus.out_x_wxd_o       = x_out.wxd;
    assign bus.out_x_reg_idxw_o  = x_out.reg_idxw;
    assign bus.out_x_wb_wxd_rd_o = x_out.wb_wxd_rd;

    assign bus.out_v_warp_id_o   = v_out.warp_id;
    assign bus.out_v_wvd_o       = v_out.wvd;
    assign bus.out_v_reg_idxw_o  = v_out.reg_idxw;
    assign bus.out_v_wvd_mask_o  = v_out.wvd_mask;
    assign bus.out_v_wb_wvd_rd_o = v_out.wb_wvd_rd;

endmodule

// File: tb/tb_writeback_rr.sv
// Bench for writeback_rr: directed scenarios plus random traffic against a transaction-level model.
module tb_writeback_rr;
    import writeback_rr_pkg::*;

    localparam int NX = 6;
    localparam int NV = 6;
    localparam int XW = DEPTH_WARP + 1 + REGW + XLEN;
    localparam int VW = DEPTH_WARP + 1 + REGW + NUM_THREAD + XLEN*NUM_THREAD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_rr_if #(.NUM_X(NX), .NUM_V(NV)) bus();
    writeback_rr #(.NUM_X(NX), .NUM_V(NV)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Model: slot occupancy, priority pointer and the entry each slot must show.
    bit             mvx, mvv;
    int             ptrx, ptrv;
    logic [XW-1:0]  sbx[$];
    logic [VW-1:0]  sbv[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [15:0] valid, input int n, input int ptr);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (ptr + k) % n;
            if (valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [XW-1:0] src_x(input int n);
        return {bus.in_x_warp_id_i[n*DEPTH_WARP +: DEPTH_WARP], bus.in_x_wxd_i[n],
                bus.in_x_reg_idxw_i[n*REGW +: REGW], bus.in_x_wb_wxd_rd_i[n*XLEN +: XLEN]};
    endfunction

    function automatic logic [VW-1:0] src_v(input int m);
        return {bus.in_v_warp_id_i[m*DEPTH_WARP +: DEPTH_WARP], bus.in_v_wvd_i[m],
                bus.in_v_reg_idxw_i[m*REGW +: REGW], bus.in_v_wvd_mask_i[m*NUM_THREAD +: NUM_THREAD],
                bus.in_v_wb_wvd_rd_i[m*XLEN*NUM_THREAD +: XLEN*NUM_THREAD]};
    endfunction

    function automatic logic [XW-1:0] obs_x();
        return {bus.out_x_warp_id_o, bus.out_x_wxd_o, bus.out_x_reg_idxw_o, bus.out_x_wb_wxd_rd_o};
    endfunction

    function automatic logic [VW-1:0] obs_v();
        return {bus.out_v_warp_id_o, bus.out_v_wvd_o, bus.out_v_reg_idxw_o,
                bus.out_v_wvd_mask_o, bus.out_v_wb_wvd_rd_o};
    endfunction

    task automatic model_clear();
        mvx = 0; mvv = 0; ptrx = 0; ptrv = 0;
        sbx.delete(); sbv.delete();
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic tick();
        int gx, gv;
        bit fx, fv, acc_x, acc_v, drn_x, drn_v;
        logic [XW-1:0] nx;
        logic [VW-1:0] nv;
        #1;
        gx = pick(16'(bus.in_x_valid_i), NX, ptrx);
        gv = pick(16'(bus.in_v_valid_i), NV, ptrv);
        fx = !mvx || bus.out_x_ready_i;
        fv = !mvv || bus.out_v_ready_i;
        acc_x = (gx >= 0) && fx;
        acc_v = (gv >= 0) && fv;
        drn_x = mvx && bus.out_x_ready_i;
        drn_v = mvv && bus.out_v_ready_i;
        chk("x_ready", bus.in_x_ready_o, acc_x ? (1 << gx) : 0);
        chk("v_ready", bus.in_v_ready_o, acc_v ? (1 << gv) : 0);
        chk("x_valid", bus.out_x_valid_o, mvx);
        chk("v_valid", bus.out_v_valid_o, mvv);
        if (mvx) chk("x_data", obs_x(), sbx[0]);
        if (mvv) chk("v_data", obs_v(), sbv[0]);
        nx = acc_x ? src_x(gx) : '0;
        nv = acc_v ? src_v(gv) : '0;
        @(posedge clk);
        if (drn_x) void'(sbx.pop_front());
        if (drn_v) void'(sbv.pop_front());
        if (acc_x) begin
            sbx.push_back(nx);
`ifdef WB_ROUND_ROBIN_EN
            ptrx = (gx + 1) % NX;
`endif
        end
        if (acc_v) begin
            sbv.push_back(nv);
`ifdef WB_ROUND_ROBIN_EN
            ptrv = (gv + 1) % NV;
`endif
        end
        mvx = acc_x ? 1'b1 : (drn_x ? 1'b0 : mvx);
        mvv = acc_v ? 1'b1 : (drn_v ? 1'b0 : mvv);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_x_valid", bus.out_x_valid_o, 0);
        chk("rst_v_valid", bus.out_v_valid_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tag_payload();
        for (int n = 0; n < NX; n++) begin
            bus.in_x_warp_id_i[n*DEPTH_WARP +: DEPTH_WARP] = DEPTH_WARP'(n);
            bus.in_x_wxd_i[n] = 1'b1;
            bus.in_x_reg_idxw_i[n*REGW +: REGW] = REGW'(n + 8);
            bus.in_x_wb_wxd_rd_i[n*XLEN +: XLEN] = 32'h1000 + n;
        end
        for (int m = 0; m < NV; m++) begin
            bus.in_v_warp_id_i[m*DEPTH_WARP +: DEPTH_WARP] = DEPTH_WARP'(m);
            bus.in_v_wvd_i[m] = 1'b1;
            bus.in_v_reg_idxw_i[m*REGW +: REGW] = REGW'(m + 16);
            bus.in_v_wvd_mask_i[m*NUM_THREAD +: NUM_THREAD] = NUM_THREAD'(m);
            for (int t = 0; t < NUM_THREAD; t++)
                bus.in_v_wb_wvd_rd_i[(m*NUM_THREAD+t)*XLEN +: XLEN] = 32'h2000 + m*16 + t;
        end
    endtask

    task automatic rand_payload();
        for (int n = 0; n < NX; n++) begin
            bus.in_x_warp_id_i[n*DEPTH_WARP +: DEPTH_WARP] = DEPTH_WARP'($urandom);
            bus.in_x_wxd_i[n] = 1'($urandom_range(0, 1));
            bus.in_x_reg_idxw_i[n*REGW +: REGW] = REGW'($urandom);
            bus.in_x_wb_wxd_rd_i[n*XLEN +: XLEN] = $urandom;
        end
        for (int m = 0; m < NV; m++) begin
            bus.in_v_warp_id_i[m*DEPTH_WARP +: DEPTH_WARP] = DEPTH_WARP'($urandom);
            bus.in_v_wvd_i[m] = 1'($urandom_range(0, 1));
            bus.in_v_reg_idxw_i[m*REGW +: REGW] = REGW'($urandom);
            bus.in_v_wvd_mask_i[m*NUM_THREAD +: NUM_THREAD] = NUM_THREAD'($urandom);
            for (int t = 0; t < NUM_THREAD; t++)
                bus.in_v_wb_wvd_rd_i[(m*NUM_THREAD+t)*XLEN +: XLEN] = $urandom;
        end
    endtask

    initial begin
        logic [XLEN*NUM_THREAD-1:0] held_v;
`ifdef WB_ROUND_ROBIN_EN
        int seq[6] = '{0, 2, 5, 0, 2, 5};
`else
        int seq[6] = '{0, 0, 0, 0, 0, 0};
`endif
        rst = 1'b1;
        bus.in_x_valid_i = '0; bus.in_v_valid_i = '0;
        bus.out_x_ready_i = 1'b1; bus.out_v_ready_i = 1'b1;
        tag_payload();
        model_clear();
        do_reset();

        // Single x source 3 with a known payload; one-cycle latency.
        bus.in_x_reg_idxw_i[3*REGW +: REGW] = 8'h1A;
        bus.in_x_wb_wxd_rd_i[3*XLEN +: XLEN] = 32'hDEADBEEF;
        bus.in_x_valid_i = 6'b001000;
        #1 chk("single_ready", bus.in_x_ready_o, 6'b001000);
        tick();
        bus.in_x_valid_i = '0;
        chk("single_valid", bus.out_x_valid_o, 1);
        chk("single_reg", bus.out_x_reg_idxw_o, 8'h1A);
        chk("single_rd", bus.out_x_wb_wxd_rd_o, 32'hDEADBEEF);
        tick();
        tick();

        // Sources 0,2,5 requesting continuously.
        do_reset();
        tag_payload();
        bus.in_x_valid_i = 6'b100101;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_seq", bus.out_x_wb_wxd_rd_o, 32'h1000 + seq[k]);
        end
        bus.in_x_valid_i = '0;
        tick();

        // Wrap: source 5 accepted, then 0 and 5 compete.
        do_reset();
        bus.in_x_valid_i = 6'b100000;
        tick();
        bus.in_x_valid_i = 6'b100001;
        #1 chk("wrap_ready", bus.in_x_ready_o, 6'b000001);
        tick();
        bus.in_x_valid_i = '0;
        tick();

        // v backpressure: slot held for 4 cycles, then released.
        do_reset();
        bus.out_v_ready_i = 1'b0;
        bus.in_v_valid_i = 6'b000001;
        tick();
        held_v = bus.out_v_wb_wvd_rd_o;
        bus.in_v_valid_i = 6'b010010;
        for (int k = 0; k < 4; k++) begin
            #1 chk("stall_ready", bus.in_v_ready_o, 0);
            chk("stall_data", bus.out_v_wb_wvd_rd_o, held_v);
            tick();
        end
        bus.out_v_ready_i = 1'b1;
        #1 chk("release_ready", bus.in_v_ready_o, 6'b000010);
        tick();
        bus.in_v_valid_i = '0;
        tick();
        tick();

        // Asynchronous reset while the x slot is stalled.
        do_reset();
        bus.out_x_ready_i = 1'b0;
        bus.in_x_valid_i = 6'b000100;
        tick();
        bus.in_x_valid_i = '0;
        tick();
        rst = 1'b1;
        #1 chk("async_rst_valid", bus.out_x_valid_o, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        bus.out_x_ready_i = 1'b1;
        tick();
        tick();
        bus.in_x_valid_i = 6'b111111;
        #1 chk("post_rst_grant", bus.in_x_ready_o, 6'b000001);
        tick();
        bus.in_x_valid_i = '0;
        tick();

        // Random traffic, x ready toggling, v always ready.
        for (int k = 0; k < 200; k++) begin
            rand_payload();
            bus.in_x_valid_i = NX'($urandom);
            bus.in_v_valid_i = NV'($urandom) | NV'(1 << $urandom_range(0, NV-1));
            bus.out_x_ready_i = k[0];
            bus.out_v_ready_i = 1'b1;
            tick();
        end

        // Random traffic with random backpressure on both channels.
        for (int k = 0; k < 300; k++) begin
            rand_payload();
            bus.in_x_valid_i = NX'($urandom);
            bus.in_v_valid_i = NV'($urandom);
            bus.out_x_ready_i = 1'($urandom_range(0, 1));
            bus.out_v_ready_i = 1'($urandom_range(0, 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
